// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, read-master state enum and burst sizing helper
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_FINISH
    } rd_state_e;

    // AxLEN for the next burst: min(remaining, max_beats) - 1; remaining must be non-zero.
    function automatic logic [7:0] arlen_for(input logic [15:0] remaining,
                                             input logic [15:0] max_beats);
        return (remaining > max_beats) ? 8'(max_beats - 16'd1) : 8'(remaining - 16'd1);
    endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// rtl/axi_sync_fifo.sv - synchronous FIFO whose read data comes straight from the storage registers
module axi_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  push;
    logic                  pop;

    assign full_o     = (count_q == FULL_COUNT);
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    // A pop cannot make room for a same-cycle push: full blocks the write regardless.
    assign push       = wr_valid_i && !full_o;
    assign pop        = rd_ready_i && rd_valid_o;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + COUNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - splits a read command into INCR bursts and streams beats out via a FIFO
module axi_burst_read_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int MAX_BURST_BEATS = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [15:0]              cmd_beats,
    input  logic [2:0]               cmd_size,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic [1:0]               err
);

    localparam logic [15:0] MAX_BEATS = 16'(MAX_BURST_BEATS);

    rd_state_e                state_q;
    logic [ADDRESS_WIDTH-1:0] araddr_q;
    logic [ADDRESS_WIDTH-1:0] next_addr_q;
    logic [7:0]               arlen_q;
    logic [2:0]               size_q;
    logic [15:0]              total_q;
    logic [8:0]               burst_q;
    logic                     arvalid_q;
    logic                     done_q;
    logic [1:0]               err_q;

    logic        cmd_fire;
    logic        ar_fire;
    logic        r_fire;
    logic        fifo_full;
    logic        beat_is_last;
    logic [15:0] total_dec;
    logic [8:0]  ar_beats;
    logic [15:0] burst_bytes;

    assign cmd_ready    = (state_q == RD_IDLE);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign ar_fire      = arvalid_q && arready;
    assign rready       = (state_q == RD_DATA) && !fifo_full;
    assign r_fire       = rvalid && rready;
    assign beat_is_last = (burst_q == 9'd1);
    assign total_dec    = total_q - 16'd1;
    assign ar_beats     = {1'b0, arlen_q} + 9'd1;
    assign burst_bytes  = {7'd0, ar_beats} << size_q;

    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = size_q;
    assign arburst = BURST_INCR;
    assign arvalid = arvalid_q;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= RD_IDLE;
            araddr_q    <= '0;
            next_addr_q <= '0;
            arlen_q     <= '0;
            size_q      <= '0;
            total_q     <= '0;
            burst_q     <= '0;
            arvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RD_IDLE: begin
                    if (cmd_fire) begin
                        err_q    <= '0;
                        size_q   <= cmd_size;
                        total_q  <= cmd_beats;
                        araddr_q <= cmd_addr;
                        arlen_q  <= arlen_for(cmd_beats, MAX_BEATS);
                        if (cmd_beats == 16'd0) begin
                            state_q <= RD_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    // Next burst start is fixed now so the last beat can re-issue without arithmetic.
                    if (ar_fire) begin
                        arvalid_q   <= 1'b0;
                        burst_q     <= ar_beats;
                        next_addr_q <= araddr_q + ADDRESS_WIDTH'(burst_bytes);
                        state_q     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        total_q <= total_dec;
                        burst_q <= burst_q - 9'd1;
                        if (rresp != RESP_OKAY) begin
                            err_q[0] <= 1'b1;
                        end
                        if (rlast != beat_is_last) begin
                            err_q[1] <= 1'b1;
                        end
                        if (beat_is_last) begin
                            if (total_dec != 16'd0) begin
                                state_q   <= RD_ADDR;
                                arvalid_q <= 1'b1;
                                araddr_q  <= next_addr_q;
                                arlen_q   <= arlen_for(total_dec, MAX_BEATS);
                            end else begin
                                state_q <= RD_FINISH;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                RD_FINISH: begin
                    state_q <= RD_IDLE;
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    axi_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_valid_i(r_fire),
        .wr_data_i (rdata),
        .full_o    (fifo_full),
        .rd_data_o (out_data),
        .rd_valid_o(out_valid),
        .rd_ready_i(out_ready)
    );

endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - directed self-checking bench with a behavioural AXI read slave
module tb_axi_burst_read_master;
    import axi_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [2:0]  cmd_size = '0;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_burst_read_master #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(8),
        .MAX_BURST_BEATS(16),
        .FIFO_DEPTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .cmd_size(cmd_size),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .err(err)
    );

    // Slave model: one burst at a time, data word = 0xA5 tag plus the beat's byte address.
    logic       s_busy;
    logic [7:0] s_addr;
    logic [8:0] s_left;
    logic [2:0] s_size;
    int         slv_beats = 0;
    int         err_beat = -1;
    int         bad_last_beat = -1;
    int         ar_cnt = 0;
    logic [7:0] ar_addr_log  [0:63];
    logic [7:0] ar_len_log   [0:63];
    logic [1:0] ar_burst_log [0:63];
    logic [2:0] ar_size_log  [0:63];

    assign arready = !s_busy;
    assign rvalid  = s_busy;
    assign rdata   = {8'hA5, 16'h0000, s_addr};
    assign rresp   = (slv_beats == err_beat) ? RESP_SLVERR : RESP_OKAY;
    assign rlast   = (s_left == 9'd1) ^ (slv_beats == bad_last_beat);

    always @(posedge aclk) begin
        if (!aresetn) begin
            s_busy <= 1'b0;
            s_addr <= '0;
            s_left <= '0;
            s_size <= '0;
        end else begin
            if (arvalid && arready) begin
                s_busy <= 1'b1;
                s_addr <= araddr;
                s_left <= {1'b0, arlen} + 9'd1;
                s_size <= arsize;
                if (ar_cnt < 64) begin
                    ar_addr_log[ar_cnt]  <= araddr;
                    ar_len_log[ar_cnt]   <= arlen;
                    ar_burst_log[ar_cnt] <= arburst;
                    ar_size_log[ar_cnt]  <= arsize;
                end
                ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) begin
                s_addr    <= s_addr + (8'd1 << s_size);
                s_left    <= s_left - 9'd1;
                slv_beats <= slv_beats + 1;
                if (s_left == 9'd1) s_busy <= 1'b0;
            end
        end
    end

    int          cyc = 0;
    int          out_cnt = 0;
    int          r_cnt = 0;
    int          done_cnt = 0;
    int          arv_cycles = 0;
    int          last_r_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] out_log [0:255];

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (aresetn) begin
            if (out_valid && out_ready) begin
                if (out_cnt < 256) out_log[out_cnt] <= out_data;
                out_cnt <= out_cnt + 1;
            end
            if (rvalid && rready) begin
                r_cnt      <= r_cnt + 1;
                last_r_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (arvalid) arv_cycles <= arv_cycles + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Returns at the negedge of the cycle right after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [15:0] b, input logic [2:0] s);
        int t;
        t = 0;
        @(negedge aclk);
        cmd_addr  = a;
        cmd_beats = b;
        cmd_size  = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int dbase, input int limit);
        int t;
        t = 0;
        while (done_cnt == dbase && t < limit) begin
            @(negedge aclk);
            t++;
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        tick(3);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", rready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
    endtask

    task automatic test_single;
        int ab, ob, db;
        ab = ar_cnt; ob = out_cnt; db = done_cnt;
        out_ready = 1'b1;
        issue(8'h10, 16'd4, 3'd2);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_latency: got %b expected 1", arvalid); end
        checks++; if (araddr !== 8'h10) begin errors++; $display("FAIL single_araddr_early: got %h expected 10", araddr); end
        wait_done(db, 200);
        tick(4);
        checks++; if (ar_cnt - ab !== 1) begin errors++; $display("FAIL single_ar_count: got %0d expected 1", ar_cnt - ab); end
        checks++; if (ar_addr_log[ab] !== 8'h10) begin errors++; $display("FAIL single_araddr: got %h expected 10", ar_addr_log[ab]); end
        checks++; if (ar_len_log[ab] !== 8'd3) begin errors++; $display("FAIL single_arlen: got %0d expected 3", ar_len_log[ab]); end
        checks++; if (ar_burst_log[ab] !== 2'b01) begin errors++; $display("FAIL single_arburst: got %b expected 01", ar_burst_log[ab]); end
        checks++; if (ar_size_log[ab] !== 3'd2) begin errors++; $display("FAIL single_arsize: got %0d expected 2", ar_size_log[ab]); end
        checks++; if (out_cnt - ob !== 4) begin errors++; $display("FAIL single_out_count: got %0d expected 4", out_cnt - ob); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_log[ob+i] !== 32'hA500_0010 + 32'(4*i)) begin
                errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, out_log[ob+i], 32'hA500_0010 + 32'(4*i));
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - db); end
        checks++; if (done_cyc !== last_r_cyc + 1) begin errors++; $display("FAIL single_done_latency: got cycle %0d expected %0d", done_cyc, last_r_cyc + 1); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL single_err: got %b expected 00", err); end
    endtask

    task automatic test_multi_burst;
        int ab, ob, db;
        logic [7:0] ea;
        logic [7:0] el;
        ab = ar_cnt; ob = out_cnt; db = done_cnt;
        issue(8'h00, 16'd40, 3'd2);
        wait_done(db, 400);
        tick(4);
        checks++; if (ar_cnt - ab !== 3) begin errors++; $display("FAIL multi_ar_count: got %0d expected 3", ar_cnt - ab); end
        for (int k = 0; k < 3; k++) begin
            ea = 8'(k * 64);
            el = (k < 2) ? 8'd15 : 8'd7;
            checks++;
            if (ar_addr_log[ab+k] !== ea || ar_len_log[ab+k] !== el) begin
                errors++; $display("FAIL multi_ar[%0d]: got addr %h len %0d expected addr %h len %0d", k, ar_addr_log[ab+k], ar_len_log[ab+k], ea, el);
            end
        end
        checks++; if (out_cnt - ob !== 40) begin errors++; $display("FAIL multi_out_count: got %0d expected 40", out_cnt - ob); end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (out_log[ob+i] !== 32'hA500_0000 + 32'(4*i)) begin
                errors++; $display("FAIL multi_data[%0d]: got %h expected %h", i, out_log[ob+i], 32'hA500_0000 + 32'(4*i));
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_wrap;
        int ab, ob, db;
        logic [7:0] lo;
        ab = ar_cnt; ob = out_cnt; db = done_cnt;
        issue(8'hF8, 16'd20, 3'd2);
        wait_done(db, 300);
        tick(4);
        checks++; if (ar_cnt - ab !== 2) begin errors++; $display("FAIL wrap_ar_count: got %0d expected 2", ar_cnt - ab); end
        checks++; if (ar_addr_log[ab] !== 8'hF8 || ar_len_log[ab] !== 8'd15) begin
            errors++; $display("FAIL wrap_ar0: got addr %h len %0d expected addr f8 len 15", ar_addr_log[ab], ar_len_log[ab]);
        end
        checks++; if (ar_addr_log[ab+1] !== 8'h38 || ar_len_log[ab+1] !== 8'd3) begin
            errors++; $display("FAIL wrap_ar1: got addr %h len %0d expected addr 38 len 3", ar_addr_log[ab+1], ar_len_log[ab+1]);
        end
        for (int i = 0; i < 20; i++) begin
            lo = 8'hF8 + 8'(4*i);
            checks++;
            if (out_log[ob+i] !== {8'hA5, 16'h0000, lo}) begin
                errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, out_log[ob+i], {8'hA5, 16'h0000, lo});
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_backpressure;
        int ob, db, rb;
        ob = out_cnt; db = done_cnt; rb = r_cnt;
        out_ready = 1'b0;
        issue(8'h20, 16'd12, 3'd2);
        tick(40);
        checks++; if (r_cnt - rb !== 8) begin errors++; $display("FAIL bp_beats_before_full: got %0d expected 8", r_cnt - rb); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL bp_rready_full: got %b expected 0", rready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'hA500_0020) begin errors++; $display("FAIL bp_head_data: got %h expected a5000020", out_data); end
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL bp_early_done: got %0d expected 0", done_cnt - db); end
        out_ready = 1'b1;
        wait_done(db, 200);
        tick(10);
        checks++; if (out_cnt - ob !== 12) begin errors++; $display("FAIL bp_out_count: got %0d expected 12", out_cnt - ob); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out_log[ob+i] !== 32'hA500_0020 + 32'(4*i)) begin
                errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, out_log[ob+i], 32'hA500_0020 + 32'(4*i));
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_zero_beats;
        int ab, db, vb;
        ab = ar_cnt; db = done_cnt; vb = arv_cycles;
        issue(8'h30, 16'd0, 3'd2);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_latency: got %b expected 1", done); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL zero_arvalid: got %b expected 0", arvalid); end
        tick(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_cmd_ready: got %b expected 1", cmd_ready); end
        tick(3);
        checks++; if (arv_cycles !== vb || ar_cnt !== ab) begin
            errors++; $display("FAIL zero_no_ar: got %0d arvalid cycles %0d ARs expected 0 0", arv_cycles - vb, ar_cnt - ab);
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_errors;
        int ob, db;
        out_ready = 1'b1;
        db = done_cnt;
        err_beat = slv_beats + 2;
        issue(8'h40, 16'd4, 3'd2);
        wait_done(db, 200);
        tick(1);
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL slverr_flag: got %b expected 01", err); end
        tick(5);
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL slverr_sticky: got %b expected 01", err); end
        err_beat = -1;
        bad_last_beat = slv_beats + 1;
        ob = out_cnt; db = done_cnt;
        issue(8'h50, 16'd4, 3'd2);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL err_clear_on_accept: got %b expected 00", err); end
        wait_done(db, 200);
        tick(4);
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL rlast_mismatch_flag: got %b expected 10", err); end
        checks++; if (out_cnt - ob !== 4) begin errors++; $display("FAIL rlast_mismatch_beats: got %0d expected 4", out_cnt - ob); end
        checks++; if (out_log[ob+1] !== 32'hA500_0054) begin errors++; $display("FAIL rlast_mismatch_data: got %h expected a5000054", out_log[ob+1]); end
        bad_last_beat = -1;
    endtask

    task automatic test_reset_mid_burst;
        int ab, ob, db, rb, t;
        out_ready = 1'b1;
        db = done_cnt; rb = r_cnt; t = 0;
        issue(8'h00, 16'd8, 3'd2);
        while (r_cnt - rb < 3 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        checks++; if (r_cnt - rb !== 3) begin errors++; $display("FAIL rst_mid_beats: got %0d expected 3", r_cnt - rb); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_mid_rready: got %b expected 0", rready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", cmd_ready); end
        aresetn = 1'b1;
        tick(3);
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_cnt - db); end
        ab = ar_cnt; ob = out_cnt; db = done_cnt;
        issue(8'h80, 16'd4, 3'd2);
        wait_done(db, 200);
        tick(4);
        checks++; if (ar_cnt - ab !== 1 || ar_addr_log[ab] !== 8'h80) begin
            errors++; $display("FAIL rst_fresh_ar: got %0d ARs addr %h expected 1 ARs addr 80", ar_cnt - ab, ar_addr_log[ab]);
        end
        checks++; if (out_cnt - ob !== 4) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 4", out_cnt - ob); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_log[ob+i] !== 32'hA500_0080 + 32'(4*i)) begin
                errors++; $display("FAIL rst_fresh_data[%0d]: got %h expected %h", i, out_log[ob+i], 32'hA500_0080 + 32'(4*i));
            end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL rst_fresh_done: got %0d expected 1", done_cnt - db); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_burst();
        test_wrap();
        test_backpressure();
        test_zero_beats();
        test_errors();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
